// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one uart_tx between NUM_REQ byte streams.
// Optional UART_TX_ARB_HDR_EN prefixes each grant with a {4'hA, id} header byte.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_en_i,
  input  logic [7:0]           cfg_gap_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ*8-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [7:0]           uart_tx_data_o,
  output logic                 uart_tx_valid_o,
  input  logic                 uart_tx_ready_i,
  input  logic                 uart_busy_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 active_o,
  output logic                 abort_o
);
  localparam int IW = $clog2(NUM_REQ);

`ifdef UART_TX_ARB_HDR_EN
  typedef enum logic [2:0] {IDLE, SEND, DRAIN, GAP, HDR, DRAIN_HDR} state_t;
`else
  typedef enum logic [2:0] {IDLE, SEND, DRAIN, GAP} state_t;
`endif

  state_t             state;
  logic [IW-1:0]      last_q;
  logic [IW-1:0]      gidx;
  logic [NUM_REQ-1:0] grant_q;
  logic [7:0]         cnt;
  logic [7:0]         gap_cnt;
  logic               abort_q;

  logic [IW-1:0]      win_idx;
  logic [IW:0]        cand;
  logic               found;
  logic               in_pkt;
  logic               xfer;

  // Search starts just after the previous owner so nobody wins twice while others wait.
  always_comb begin
    win_idx = last_q;
    found   = 1'b0;
    cand    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, last_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      if (!found && req_valid_i[cand[IW-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[IW-1:0];
      end
    end
  end

`ifdef UART_TX_ARB_HDR_EN
  assign in_pkt = (state == SEND) || (state == HDR) || (state == DRAIN_HDR);
`else
  assign in_pkt = (state == SEND);
`endif

  assign xfer = req_valid_i[gidx] && uart_tx_ready_i;

  always_comb begin
    req_ready_o     = '0;
    uart_tx_valid_o = 1'b0;
    uart_tx_data_o  = req_data_i[{gidx, 3'b000} +: 8];
    case (state)
      SEND: begin
        uart_tx_valid_o = req_valid_i[gidx];
        req_ready_o     = grant_q & {NUM_REQ{uart_tx_ready_i}};
      end
`ifdef UART_TX_ARB_HDR_EN
      HDR: begin
        uart_tx_valid_o = 1'b1;
        uart_tx_data_o  = {4'hA, 4'(gidx)};
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      last_q  <= IW'(NUM_REQ - 1);
      gidx    <= '0;
      grant_q <= '0;
      cnt     <= '0;
      gap_cnt <= '0;
      abort_q <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      if (state != IDLE && !cfg_en_i) begin
        // Cancelled owner counts as served; its packet is not resumed.
        state   <= IDLE;
        grant_q <= '0;
        last_q  <= gidx;
        abort_q <= in_pkt;
      end else begin
        case (state)
          IDLE: begin
            if (cfg_en_i && found) begin
              grant_q <= NUM_REQ'(1) << win_idx;
              gidx    <= win_idx;
              cnt     <= '0;
`ifdef UART_TX_ARB_HDR_EN
              state   <= HDR;
`else
              state   <= SEND;
`endif
            end
          end
`ifdef UART_TX_ARB_HDR_EN
          HDR: begin
            if (uart_tx_ready_i) state <= DRAIN_HDR;
          end
          DRAIN_HDR: begin
            if (!uart_busy_i) state <= SEND;
          end
`endif
          SEND: begin
            if (xfer) begin
              cnt <= cnt + 8'd1;
              if (req_last_i[gidx] || (cnt + 8'd1 == 8'(MAX_BURST))) state <= DRAIN;
            end
          end
          DRAIN: begin
            if (!uart_busy_i) begin
              last_q  <= gidx;
              grant_q <= '0;
              if (cfg_gap_i == 8'd0) begin
                state <= IDLE;
              end else begin
                gap_cnt <= cfg_gap_i;
                state   <= GAP;
              end
            end
          end
          GAP: begin
            if (gap_cnt <= 8'd1) state <= IDLE;
            else gap_cnt <= gap_cnt - 8'd1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign grant_o  = grant_q;
  assign active_o = (state != IDLE);
  assign abort_o  = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized self-checking bench for uart_tx_arbiter against a packet-level round-robin model.
module tb_uart_tx_arbiter;
  localparam int NUM = 4;
  localparam int MB  = 4;
`ifdef UART_TX_ARB_HDR_EN
  localparam int HB = 1;
`else
  localparam int HB = 0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           cfg_en;
  logic [7:0]     cfg_gap;
  logic [NUM-1:0] req_valid;
  logic [NUM*8-1:0] req_data;
  logic [NUM-1:0] req_last;
  logic [NUM-1:0] req_ready;
  logic [7:0]     uart_tx_data;
  logic           uart_tx_valid;
  logic           uart_ready;
  logic           busy;
  logic [NUM-1:0] grant;
  logic           active;
  logic           abort;

  int tests_run = 0;
  int tests_failed = 0;

  logic [8:0] rq [NUM][$];
  logic [8:0] mq [NUM][$];
  bit   stall [NUM];
  int   log_q[$];
  int   exp_q[$];
  int   log_base = 0;
  int   viol = 0;
  int   busy_cnt = 0;
  int   frame_len = 5;

  assign busy       = (busy_cnt != 0);
  assign uart_ready = cfg_en && !busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NUM), .MAX_BURST(MB)) dut (
    .clk_i(clk), .rst_i(rst), .cfg_en_i(cfg_en), .cfg_gap_i(cfg_gap),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
    .req_ready_o(req_ready), .uart_tx_data_o(uart_tx_data),
    .uart_tx_valid_o(uart_tx_valid), .uart_tx_ready_i(uart_ready),
    .uart_busy_i(busy), .grant_o(grant), .active_o(active), .abort_o(abort)
  );

  function automatic int idx_of(input logic [NUM-1:0] g);
    int r = 15;
    for (int k = NUM-1; k >= 0; k--) if (g[k]) r = k;
    return r;
  endfunction

  // UART and requester environment: sample handshakes mid-cycle, apply them after the edge.
  initial begin : env
    logic           ufire;
    logic [7:0]     udat;
    logic [NUM-1:0] ugnt;
    logic [NUM-1:0] rfire;
    forever begin
      @(negedge clk);
      ufire = uart_tx_valid && uart_ready;
      udat  = uart_tx_data;
      ugnt  = grant;
      rfire = req_ready & req_valid;
      for (int k = 0; k < NUM; k++) if (req_ready[k] && !grant[k]) viol++;
      @(posedge clk);
      #1;
      if (rst) begin
        busy_cnt = 0;
      end else begin
        if (busy_cnt > 0) busy_cnt--;
        if (ufire) begin
          log_q.push_back(idx_of(ugnt) * 256 + int'(udat));
          busy_cnt = frame_len;
        end
        for (int k = 0; k < NUM; k++)
          if (rfire[k] && rq[k].size() > 0) void'(rq[k].pop_front());
      end
      for (int k = 0; k < NUM; k++) begin
        req_valid[k]       = (rq[k].size() > 0) && !stall[k];
        req_data[k*8 +: 8] = (rq[k].size() > 0) ? rq[k][0][7:0] : 8'h00;
        req_last[k]        = (rq[k].size() > 0) ? rq[k][0][8] : 1'b0;
      end
    end
  end

  // Reference: packets served whole in round-robin order, split every MB bytes.
  task automatic build_exp();
    int ptr, w, n;
    bit more, stop;
    logic [8:0] e;
    exp_q.delete();
    for (int k = 0; k < NUM; k++) mq[k] = rq[k];
    ptr  = NUM - 1;
    more = 1;
    while (more) begin
      w = -1;
      for (int i = 1; i <= NUM; i++)
        if (w < 0 && mq[(ptr + i) % NUM].size() > 0) w = (ptr + i) % NUM;
      if (w < 0) begin
        more = 0;
      end else begin
        if (HB == 1) exp_q.push_back(w * 256 + 160 + w);
        n = 0;
        stop = 0;
        while (!stop) begin
          e = mq[w].pop_front();
          exp_q.push_back(w * 256 + int'(e[7:0]));
          n++;
          stop = e[8] || (n == MB) || (mq[w].size() == 0);
        end
        ptr = w;
      end
    end
  endtask

  function automatic int first_diff();
    int n = log_q.size() - log_base;
    if (n != exp_q.size()) return (n < exp_q.size()) ? n : exp_q.size();
    for (int i = 0; i < n; i++) if (log_q[log_base + i] != exp_q[i]) return i;
    return -1;
  endfunction

  function automatic int got_at(input int d);
    return (log_base + d < log_q.size()) ? log_q[log_base + d] : -1;
  endfunction

  function automatic int exp_at(input int d);
    return (d < exp_q.size()) ? exp_q[d] : -1;
  endfunction

  task automatic wait_log(input int n, input int budget, output bit ok);
    int i = 0;
    ok = (log_q.size() - log_base >= n);
    while (!ok && i < budget) begin
      @(negedge clk);
      i++;
      ok = (log_q.size() - log_base >= n);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst    = 1'b1;
    cfg_en = 1'b0;
    cfg_gap = 8'd0;
    for (int k = 0; k < NUM; k++) begin
      rq[k].delete();
      stall[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    log_base = log_q.size();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    reset_dut();
    frame_len = 5;
    rq[3].push_back({1'b1, 8'h33});
    rq[0].push_back({1'b1, 8'h11});
    build_exp();
    rst = 1'b1;
    cfg_en = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (grant !== 4'b0000) begin tests_failed++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    tests_run++;
    if (active !== 1'b0 || abort !== 1'b0) begin tests_failed++; $display("FAIL reset_flags: active %b abort %b expected 0 0", active, abort); end
    tests_run++;
    if (uart_tx_valid !== 1'b0 || req_ready !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_handshake: valid %b ready %b expected 0 0000", uart_tx_valid, req_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (grant !== 4'b0001) begin tests_failed++; $display("FAIL reset_first_priority: got %b expected 0001", grant); end
    wait_log(exp_q.size(), 500, ok);
    tests_run++;
    if (first_diff() !== -1) begin
      tests_failed++; $display("FAIL reset_order: entry %0d got %h expected %h", first_diff(), got_at(first_diff()), exp_at(first_diff()));
    end
  endtask

  task automatic test_single();
    bit ok;
    int gbad = 0;
    int gap_cycles = 0;
    int i = 0;
    reset_dut();
    frame_len = 6;
    cfg_gap = 8'd3;
    rq[1].push_back({1'b0, 8'h55});
    rq[1].push_back({1'b1, 8'h0F});
    build_exp();
    cfg_en = 1'b1;
    ok = 0;
    while (!ok && i < 500) begin
      @(negedge clk);
      i++;
      if (grant !== 4'b0000 && grant !== 4'b0010) gbad++;
      ok = (log_q.size() - log_base >= 2 + HB);
    end
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL single_timeout: got %0d bytes expected %0d", log_q.size() - log_base, 2 + HB); end
    i = 0;
    while (busy && i < 100) begin @(negedge clk); i++; end
    while (active && gap_cycles < 50) begin
      @(negedge clk);
      gap_cycles++;
      if (grant !== 4'b0000 && grant !== 4'b0010) gbad++;
    end
    tests_run++;
    if (gap_cycles !== 4) begin tests_failed++; $display("FAIL single_gap: active fell %0d cycles after busy, expected 4", gap_cycles); end
    tests_run++;
    if (gbad !== 0) begin tests_failed++; $display("FAIL single_grant: %0d cycles with grant other than 0010, expected 0", gbad); end
    tests_run++;
    if (first_diff() !== -1) begin
      tests_failed++; $display("FAIL single_bytes: entry %0d got %h expected %h", first_diff(), got_at(first_diff()), exp_at(first_diff()));
    end
  endtask

  task automatic test_contention();
    bit ok;
    int v0;
    reset_dut();
    v0 = viol;
    frame_len = $urandom_range(2, 6);
    cfg_gap = 8'($urandom_range(0, 3));
    for (int p = 0; p < 2; p++) begin
      rq[0].push_back({1'b1, 8'($urandom_range(0, 255))});
      rq[2].push_back({1'b1, 8'($urandom_range(0, 255))});
      rq[3].push_back({1'b1, 8'($urandom_range(0, 255))});
    end
    build_exp();
    cfg_en = 1'b1;
    wait_log(exp_q.size(), 1000, ok);
    tests_run++;
    if (first_diff() !== -1) begin
      tests_failed++; $display("FAIL contention_order: entry %0d got %h expected %h", first_diff(), got_at(first_diff()), exp_at(first_diff()));
    end
    tests_run++;
    if (viol - v0 !== 0) begin tests_failed++; $display("FAIL contention_foreign_ready: got %0d ungranted readies expected 0", viol - v0); end
  endtask

  task automatic test_burst();
    bit ok;
    int v0;
    reset_dut();
    v0 = viol;
    frame_len = 3;
    cfg_gap = 8'd1;
    for (int b = 0; b < 10; b++) rq[0].push_back({1'b0, 8'($urandom_range(0, 255))});
    rq[1].push_back({1'b0, 8'($urandom_range(0, 255))});
    rq[1].push_back({1'b1, 8'($urandom_range(0, 255))});
    build_exp();
    cfg_en = 1'b1;
    wait_log(exp_q.size(), 2000, ok);
    repeat (10) @(negedge clk);
    tests_run++;
    if (first_diff() !== -1) begin
      tests_failed++; $display("FAIL burst_order: entry %0d got %h expected %h", first_diff(), got_at(first_diff()), exp_at(first_diff()));
    end
    tests_run++;
    if (viol - v0 !== 0) begin tests_failed++; $display("FAIL burst_foreign_ready: got %0d expected 0", viol - v0); end
    tests_run++;
    if (grant !== 4'b0001 || active !== 1'b1) begin
      tests_failed++; $display("FAIL burst_hold: grant %b active %b expected 0001 1", grant, active);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (grant !== 4'b0000 || active !== 1'b0) begin
      tests_failed++; $display("FAIL async_reset: grant %b active %b expected 0000 0", grant, active);
    end
  endtask

  task automatic test_stall();
    bit ok;
    int snap;
    int bad = 0;
    reset_dut();
    frame_len = 4;
    cfg_gap = 8'd2;
    for (int b = 0; b < 4; b++) rq[0].push_back({(b == 3), 8'($urandom_range(0, 255))});
    rq[2].push_back({1'b1, 8'($urandom_range(0, 255))});
    build_exp();
    cfg_en = 1'b1;
    wait_log(2 + HB, 500, ok);
    stall[0] = 1'b1;
    repeat (3) @(negedge clk);
    snap = log_q.size();
    repeat (20) begin
      @(negedge clk);
      if (grant !== 4'b0001) bad++;
      if (uart_tx_valid !== 1'b0) bad++;
    end
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("FAIL stall_hold: got %0d bad cycles expected 0", bad); end
    tests_run++;
    if (log_q.size() !== snap) begin tests_failed++; $display("FAIL stall_no_bytes: got %0d entries expected %0d", log_q.size(), snap); end
    stall[0] = 1'b0;
    wait_log(exp_q.size(), 1000, ok);
    tests_run++;
    if (first_diff() !== -1) begin
      tests_failed++; $display("FAIL stall_order: entry %0d got %h expected %h", first_diff(), got_at(first_diff()), exp_at(first_diff()));
    end
  endtask

  task automatic test_abort();
    bit ok;
    reset_dut();
    frame_len = 6;
    cfg_gap = 8'd0;
    for (int b = 0; b < 3; b++) rq[1].push_back({(b == 2), 8'($urandom_range(0, 255))});
    rq[2].push_back({1'b1, 8'h77});
    cfg_en = 1'b1;
    wait_log(1 + HB, 500, ok);
    cfg_en = 1'b0;
    @(negedge clk);
    tests_run++;
    if (grant !== 4'b0000 || abort !== 1'b1) begin
      tests_failed++; $display("FAIL abort_cancel: grant %b abort %b expected 0000 1", grant, abort);
    end
    tests_run++;
    if (uart_tx_valid !== 1'b0 || active !== 1'b0) begin
      tests_failed++; $display("FAIL abort_idle: valid %b active %b expected 0 0", uart_tx_valid, active);
    end
    @(negedge clk);
    tests_run++;
    if (abort !== 1'b0) begin tests_failed++; $display("FAIL abort_pulse: got %b expected 0", abort); end
    cfg_en = 1'b1;
    @(negedge clk);
    tests_run++;
    if (grant !== 4'b0100) begin tests_failed++; $display("FAIL abort_next_owner: got %b expected 0100", grant); end
  endtask

`ifdef UART_TX_ARB_HDR_EN
  task automatic test_header();
    int bad = 0;
    int i = 0;
    bit ok;
    reset_dut();
    frame_len = 4;
    rq[2].push_back({1'b1, 8'h41});
    build_exp();
    cfg_en = 1'b1;
    while (log_q.size() - log_base < 1 && i < 300) begin
      @(negedge clk);
      i++;
      if (req_ready !== 4'b0000) bad++;
    end
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("FAIL header_ready: got %0d ready cycles expected 0", bad); end
    wait_log(2, 300, ok);
    tests_run++;
    if (first_diff() !== -1) begin
      tests_failed++; $display("FAIL header_bytes: entry %0d got %h expected %h", first_diff(), got_at(first_diff()), exp_at(first_diff()));
    end
  endtask
`endif

  task automatic test_random();
    bit ok;
    int v0, np, len, i;
    for (int it = 0; it < 3; it++) begin
      reset_dut();
      v0 = viol;
      frame_len = $urandom_range(1, 8);
      cfg_gap = 8'($urandom_range(0, 4));
      for (int k = 0; k < NUM; k++) begin
        np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) begin
          len = $urandom_range(1, 6);
          for (int b = 0; b < len; b++) rq[k].push_back({(b == len - 1), 8'($urandom_range(0, 255))});
        end
      end
      build_exp();
      cfg_en = 1'b1;
      wait_log(exp_q.size(), 5000, ok);
      i = 0;
      @(negedge clk);
      while (active && i < 200) begin @(negedge clk); i++; end
      tests_run++;
      if (first_diff() !== -1) begin
        tests_failed++; $display("FAIL random_order_%0d: entry %0d got %h expected %h", it, first_diff(), got_at(first_diff()), exp_at(first_diff()));
      end
      tests_run++;
      if (viol - v0 !== 0) begin tests_failed++; $display("FAIL random_foreign_ready_%0d: got %0d expected 0", it, viol - v0); end
      tests_run++;
      if (active !== 1'b0 || grant !== 4'b0000) begin
        tests_failed++; $display("FAIL random_final_idle_%0d: active %b grant %b expected 0 0000", it, active, grant);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    cfg_en = 1'b0;
    cfg_gap = 8'd0;
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    test_reset();
    test_single();
    test_contention();
    test_burst();
    test_stall();
    test_abort();
`ifdef UART_TX_ARB_HDR_EN
    test_header();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
